// File: rtl/cond_logic_pkg.sv
// Shared types for the execute-stage conditional-execution unit.
package cond_pkg;

   // ARM condition field encodings, instruction bits [31:28]
   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_t;

   // Bit positions inside a raw {N,Z,C,V} nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Field order matches the raw nibble: n is bit 3, v is bit 0
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Gated write/branch controls crossing into the M stage
   typedef struct packed {
      logic regw;
      logic memw;
      logic pcsrc;
   } mctl_t;

endpackage

// File: rtl/cond_logic_condcheck.sv
// Combinational evaluation of an ARM condition field against NZCV.
module condcheck
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  flags_t     flags,
   output logic       condex
);

   logic ge;

   assign ge = (flags.n == flags.v);

   // One term per encoding; NV is architecturally undefined and never passes
   always_comb begin
      condex = 1'b0;
      unique case (cond_t'(cond))
         EQ: condex = flags.z;
         NE: condex = ~flags.z;
         CS: condex = flags.c;
         CC: condex = ~flags.c;
         MI: condex = flags.n;
         PL: condex = ~flags.n;
         VS: condex = flags.v;
         VC: condex = ~flags.v;
         HI: condex = flags.c & ~flags.z;
         LS: condex = ~flags.c | flags.z;
         GE: condex = ge;
         LT: condex = ~ge;
         GT: condex = ~flags.z & ge;
         LE: condex = flags.z | ~ge;
         AL: condex = 1'b1;
         NV: condex = 1'b0;
         default: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Execute-stage conditional execution: NZCV register, control gating and
// the E/M boundary registers for the gated write/branch controls.
module cond_logic
   import cond_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ValidE,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   input  logic       Stall,
   input  logic       Flush,
   output logic       CondExE,
   output logic       PCSrcE,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       RegWriteM,
   output logic       MemWriteM,
   output logic       PCSrcM,
   output logic [3:0] Flags
);

   flags_t flags_q;
   mctl_t  mctl_q;
   mctl_t  mctl_e;
   logic   live;
   logic   we;

   // Condition is checked against the registered flags only, so an
   // instruction never observes its own ALU flag result.
   condcheck u_condcheck (
      .cond   (Cond),
      .flags  (flags_q),
      .condex (CondExE)
   );

   assign live = ValidE & ~Flush & CondExE;
   assign we   = live & ~Stall;

   // Gate decoder controls; NoWrite covers CMP/TST style ops
   always_comb begin
      mctl_e       = '0;
      mctl_e.pcsrc = PCS & live;
      mctl_e.regw  = RegW & ~NoWrite & live;
      mctl_e.memw  = MemW & live;
   end

   assign PCSrcE    = mctl_e.pcsrc;
   assign RegWriteE = mctl_e.regw;
   assign MemWriteE = mctl_e.memw;

   // NZCV register: N,Z and C,V are independently write-enabled halves
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= flags_t'(RESET_FLAGS);
      end else if (we) begin
         if (FlagW[1]) begin
            flags_q.n <= ALUFlags[FLAG_N];
            flags_q.z <= ALUFlags[FLAG_Z];
         end
         if (FlagW[0]) begin
            flags_q.c <= ALUFlags[FLAG_C];
            flags_q.v <= ALUFlags[FLAG_V];
         end
      end
   end

   // E/M boundary: flush wins over stall so a killed slot never lingers
   always_ff @(posedge clk) begin
      if (reset) begin
         mctl_q <= '0;
      end else if (Flush) begin
         mctl_q <= '0;
      end else if (!Stall) begin
         mctl_q <= mctl_e;
      end
   end

   assign RegWriteM = mctl_q.regw;
   assign MemWriteM = mctl_q.memw;
   assign PCSrcM    = mctl_q.pcsrc;
   assign Flags     = flags_q;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
Execute-stage conditional-execution unit for the pipelined ARM core.
- Holds the architectural NZCV flag register.
- Evaluates the instruction's condition field against the current flags through the condcheck sub-module.
- Gates the decoder's write/branch controls with the result.
- Registers the gated controls into the E/M pipeline boundary.
- Sits between the decoder/ALU (upstream) and the memory/writeback control path (downstream).

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ValidE  in  1  E-stage holds a real instruction (0 = bubble)
- Cond  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle
- FlagW  in  2  [1] = write N,Z; [0] = write C,V
- PCS  in  1  instruction writes PC (branch or PC destination)
- RegW  in  1  instruction writes register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  compare-type op; suppress register write
- Stall  in  1  hold flags and M-stage registers
- Flush  in  1  kill E-stage instruction
- CondExE  out  1  condition passed (combinational)
- PCSrcE  out  1  gated PC write (combinational, to fetch mux)
- RegWriteE  out  1  gated register write (combinational, to hazard unit)
- MemWriteE  out  1  gated memory write (combinational)
- RegWriteM  out  1  registered RegWriteE
- MemWriteM  out  1  registered MemWriteE
- PCSrcM  out  1  registered PCSrcE
- Flags  out  4  current registered {N,Z,C,V}

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high. All state updates on rising clk.
- Condition evaluation:
  - CondExE = condcheck(Cond, Flags) using the registered flags, not ALUFlags. An instruction never sees its own flag result.
  - Cond = 4'b1110 gives 1. Cond = 4'b1111 gives 0 (undefined).
- Gated outputs (combinational), with live = ValidE & ~Flush & CondExE:
  - PCSrcE = PCS & live
  - RegWriteE = RegW & ~NoWrite & live
  - MemWriteE = MemW & live
- Flag register:
  - Write enable: we = live & ~Stall.
  - On an edge with we & FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - On an edge with we & FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Fields not enabled hold their value.
  - A flag-setting instruction in cycle t affects the condition of the instruction in E at cycle t+1. No bypass is required.
- M-stage registers (RegWriteM, MemWriteM, PCSrcM):
  - Latency is 1 cycle from the E outputs.
  - Stall=1: hold.
  - Flush=1: load 0 (the gating already forces the E outputs to 0).
  - Otherwise: load the E outputs.
- Priority: reset > Flush > Stall. Flush and Stall asserted together → flags unchanged and M registers cleared.
- Reset:
  - Flags = RESET_FLAGS.
  - RegWriteM = MemWriteM = PCSrcM = 0.
  - E outputs follow the reset flags combinationally.
  - Reset asserted mid-instruction discards any pending flag write on that edge.
- Boundaries:
  - ValidE=0: no flag update and zero gated outputs, regardless of the other control inputs.
  - Failed condition: no flag update even when FlagW != 0.
  - Each M register is a 1-bit plain register; there is no wrap-around or counter state.

Decomposition:
- Package cond_pkg:
  - cond_t enum of the 16 condition encodings (EQ..AL, NV).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flags_t typedef (4-bit packed struct).
- Sub-module: instantiate the existing condcheck for the combinational evaluation. The flag register and M-stage registers are local to cond_logic.

Test Plan:
- Reset, then Cond=EQ, RegW=1, ValidE=1 → CondExE=0, RegWriteE=0. Next cycle RegWriteM=0. Flags=4'b0000.
- CMP-style: Cond=AL, FlagW=2'b11, NoWrite=1, ALUFlags=4'b0110 → RegWriteE=0, and Flags=4'b0110 after the edge. Next instruction Cond=EQ, RegW=1 → RegWriteE=1, and RegWriteM=1 one cycle later.
- Partial write: Flags=4'b0110, then FlagW=2'b10, ALUFlags=4'b1001 → Flags=4'b1010 (C,V held). Then Cond=LT, PCS=1 → PCSrcE=1.
- Failed condition with FlagW=2'b11: Flags=4'b0000, Cond=EQ, ALUFlags=4'b1111 → Flags stay 4'b0000 and all gated outputs are 0.
- Stall: M registers hold 1,0,0 with Stall=1 for 3 cycles while E outputs change → M registers and Flags unchanged. Then Flush=1 with Stall=1 → M registers are 0 after the edge.
- Cond=4'b1111 with RegW=MemW=PCS=1 → all E outputs 0. Toggling ValidE=0 with Cond=AL and FlagW=2'b11 → no flag change.
